// File: rtl/cnn_stream_pkg.sv
// ----------------------------------------------------------------------------
// cnn_stream_pkg
// Shared types and constants for the convolution stream datapath.
//   state_e       : framing state of the window generator
//   DEF_PIX_WIDTH : default pixel width
//   ERR_*         : bit positions inside err_flags
//   win_idx()     : byte index of window pixel (row r, column c), r/c in 0..2
// ----------------------------------------------------------------------------
package cnn_stream_pkg;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } state_e;

  localparam int DEF_PIX_WIDTH = 8;

  localparam int ERR_EOL = 0;
  localparam int ERR_SOF = 1;
  localparam int ERR_CFG = 2;

  // Byte 0 is the top-left (oldest) pixel, byte 8 the newest one.
  function automatic int win_idx(input int r, input int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// ----------------------------------------------------------------------------
// line_buffer_ram
// Simple dual-port line memory: synchronous write, asynchronous read.
// A read and a write to the same address in one cycle return the old word.
//   clk     : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational)
// ----------------------------------------------------------------------------
module line_buffer_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: the storage array has no reset so it maps onto RAM; consumers must
  // never rely on its contents before they have been written.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/conv_window_3x3_axis.sv
// ----------------------------------------------------------------------------
// conv_window_3x3_axis
// Turns a single-channel pixel AXI-Stream into a stream of 3x3 neighbourhoods
// (valid-mode, no padding). One window per input pixel once two full rows of
// the current frame are buffered; one pixel per cycle with full backpressure.
//   clk, reset_n      : clock, asynchronous active-low reset
//   cfg_cols          : frame width, sampled on the start-of-frame beat
//   s_axis_*          : pixel input (tuser = start of frame, tlast = end of row)
//   m_axis_*          : window output, byte 3*r+c = pixel (row-2+r, col-2+c);
//                       tuser = first window of frame, tlast = last of a row
//   err_flags         : sticky {cfg, sof, eol} errors, cleared only by reset
// ----------------------------------------------------------------------------
module conv_window_3x3_axis
  import cnn_stream_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int PIX_WIDTH            = DEF_PIX_WIDTH,
  parameter int MAX_COLS             = 1024
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [15:0]                     cfg_cols,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [9*PIX_WIDTH-1:0]          m_axis_tdata,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tuser,
  output logic [2:0]                      err_flags
);

  localparam int             CW           = $clog2(MAX_COLS + 1);
  localparam int             AW           = $clog2(MAX_COLS);
  localparam int             WIN_W        = 9 * PIX_WIDTH;
  localparam logic [15:0]    MAX_COLS_CFG = 16'(MAX_COLS);
  localparam logic [CW-1:0]  COL_ONE      = CW'(1);
  localparam logic [CW-1:0]  COL_TWO      = CW'(2);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_e               r_state;
  logic [CW-1:0]        r_col;
  logic [CW-1:0]        r_cols;
  logic [1:0]           r_rows;
  logic                 r_sof_pend;
  // Last two pixels of each window row; the third column comes from the
  // line buffers and the incoming pixel.
  logic [PIX_WIDTH-1:0] r_hist [3][2];
  logic                 r_m_tvalid;
  logic [WIN_W-1:0]     r_m_tdata;
  logic                 r_m_tlast;
  logic                 r_m_tuser;
  logic [2:0]           r_err;

  // --------------------------------------------------------------------------
  // Wires
  // --------------------------------------------------------------------------
  state_e               w_state_nxt;
  logic                 w_acc;
  logic                 w_cfg_ok;
  logic                 w_start;
  logic                 w_process;
  logic                 w_mid_sof;
  logic                 w_cfg_err;
  logic [CW-1:0]        w_cols_eff;
  logic [CW-1:0]        w_pcol;
  logic [1:0]           w_prow;
  logic                 w_sof_eff;
  logic                 w_last_col;
  logic                 w_row_end;
  logic [CW-1:0]        w_col_nxt;
  logic [1:0]           w_rows_nxt;
  logic                 w_emit;
  logic                 w_eol_err;
  logic [PIX_WIDTH-1:0] w_pix;
  logic [PIX_WIDTH-1:0] w_lb0_rd;
  logic [PIX_WIDTH-1:0] w_lb1_rd;
  logic [WIN_W-1:0]     w_win;
  logic                 w_unused_tdata;

  assign w_pix          = s_axis_tdata[PIX_WIDTH-1:0];
  assign w_unused_tdata = ^s_axis_tdata[C_S_AXIS_TDATA_WIDTH-1:PIX_WIDTH];

  // Ready depends only on the output register, never on s_axis_tvalid.
  assign s_axis_tready = !r_m_tvalid || m_axis_tready;
  assign w_acc         = s_axis_tvalid && s_axis_tready;
  assign w_cfg_ok      = (cfg_cols >= 16'd3) && (cfg_cols <= MAX_COLS_CFG);

  // --------------------------------------------------------------------------
  // Framing FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= WAIT_SOF;
    end else begin
      // NOTE: sequential state is always updated with non-blocking assignments
      // so every register samples the pre-edge values of the others.
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_process   = 1'b0;
    w_mid_sof   = 1'b0;
    w_cfg_err   = 1'b0;
    if (w_acc) begin
      case (r_state)
        WAIT_SOF: begin
          if (s_axis_tuser) begin
            if (w_cfg_ok) begin
              w_start     = 1'b1;
              w_process   = 1'b1;
              w_state_nxt = ACTIVE;
            end else begin
              w_cfg_err = 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (s_axis_tuser) begin
            // A tuser at column 0 is a clean frame boundary; anywhere else
            // the current frame is abandoned.
            w_mid_sof = (r_col != '0);
            if (w_cfg_ok) begin
              w_start   = 1'b1;
              w_process = 1'b1;
            end else begin
              w_cfg_err   = 1'b1;
              w_state_nxt = WAIT_SOF;
            end
          end else begin
            w_process = 1'b1;
          end
        end
        default: w_state_nxt = WAIT_SOF;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Position of the pixel being processed (a frame start is pixel (0,0))
  // --------------------------------------------------------------------------
  assign w_cols_eff = w_start ? cfg_cols[CW-1:0] : r_cols;
  assign w_pcol     = w_start ? '0 : r_col;
  assign w_prow     = w_start ? 2'd0 : r_rows;
  assign w_sof_eff  = w_start || r_sof_pend;
  assign w_last_col = (w_pcol == (w_cols_eff - COL_ONE));
  assign w_row_end  = s_axis_tlast || w_last_col;
  assign w_col_nxt  = w_row_end ? '0 : (w_pcol + COL_ONE);
  assign w_rows_nxt = (w_row_end && (w_prow != 2'd2)) ? (w_prow + 2'd1) : w_prow;
  assign w_emit     = w_process && (w_prow == 2'd2) && (w_pcol >= COL_TWO);
  assign w_eol_err  = w_process && (s_axis_tlast != w_last_col);

  // --------------------------------------------------------------------------
  // Line buffers: lb0 holds the previous row, lb1 the one before it.
  // --------------------------------------------------------------------------
  line_buffer_ram #(
    .DEPTH (MAX_COLS),
    .WIDTH (PIX_WIDTH)
  ) u_lb0 (
    .clk     (clk),
    .i_we    (w_process),
    .i_waddr (w_pcol[AW-1:0]),
    .i_wdata (w_pix),
    .i_raddr (w_pcol[AW-1:0]),
    .o_rdata (w_lb0_rd)
  );

  line_buffer_ram #(
    .DEPTH (MAX_COLS),
    .WIDTH (PIX_WIDTH)
  ) u_lb1 (
    .clk     (clk),
    .i_we    (w_process),
    .i_waddr (w_pcol[AW-1:0]),
    .i_wdata (w_lb0_rd),
    .i_raddr (w_pcol[AW-1:0]),
    .o_rdata (w_lb1_rd)
  );

  // --------------------------------------------------------------------------
  // Window assembly for the pixel being processed
  // --------------------------------------------------------------------------
  always_comb begin
    w_win = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 2; c++) begin
        w_win[win_idx(r, c) * PIX_WIDTH +: PIX_WIDTH] = r_hist[r][c];
      end
    end
    w_win[win_idx(0, 2) * PIX_WIDTH +: PIX_WIDTH] = w_lb1_rd;
    w_win[win_idx(1, 2) * PIX_WIDTH +: PIX_WIDTH] = w_lb0_rd;
    w_win[win_idx(2, 2) * PIX_WIDTH +: PIX_WIDTH] = w_pix;
  end

  // --------------------------------------------------------------------------
  // Datapath, output register and error flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col      <= '0;
      r_cols     <= '0;
      r_rows     <= '0;
      r_sof_pend <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 2; c++) begin
          r_hist[r][c] <= '0;
        end
      end
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tuser  <= 1'b0;
      r_err      <= '0;
    end else begin
      if (w_process) begin
        r_col  <= w_col_nxt;
        r_cols <= w_cols_eff;
        r_rows <= w_rows_nxt;
        for (int r = 0; r < 3; r++) begin
          r_hist[r][0] <= r_hist[r][1];
        end
        r_hist[0][1] <= w_lb1_rd;
        r_hist[1][1] <= w_lb0_rd;
        r_hist[2][1] <= w_pix;
        // rows_seen saturates, so a separate flag marks the frame's first
        // output window.
        r_sof_pend <= w_sof_eff && !w_emit;
      end

      if (w_emit) begin
        r_m_tvalid <= 1'b1;
        r_m_tdata  <= w_win;
        r_m_tlast  <= w_last_col;
        r_m_tuser  <= w_sof_eff;
      end else if (m_axis_tready) begin
        r_m_tvalid <= 1'b0;
      end

      if (w_eol_err) r_err[ERR_EOL] <= 1'b1;
      if (w_mid_sof) r_err[ERR_SOF] <= 1'b1;
      if (w_cfg_err) r_err[ERR_CFG] <= 1'b1;
    end
  end

  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tlast  = r_m_tlast;
  assign m_axis_tuser  = r_m_tuser;
  assign err_flags     = r_err;

endmodule
